rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux.sv | 93 +++++++++
 tb/tb_rr_arb_mux.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// Round-robin N_IN:1 arbiter feeding one registered output stage with valid/ready handshake.
// Define RR_ARB_MUX_LOCK_EN to add packet locking (in_last/out_last ports).
module rr_arb_mux #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 32,
  parameter int SELW  = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [N_IN-1:0]       in_last,
  output logic                  out_last,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_sel
);

  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] grant;
  logic [SELW-1:0] ptr_nxt;
  logic [SELW:0]   idx;
  logic            grant_vld;
  logic            can_load;
  logic            take;

`ifdef RR_ARB_MUX_LOCK_EN
  logic            locked;
  logic [SELW-1:0] lock_ch;
`endif

  // First requester at or above rr_ptr, wrapping; idx has one spare bit for the wrap.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (SELW+1)'(k);
      if (idx >= (SELW+1)'(N_IN))
        idx = idx - (SELW+1)'(N_IN);
      if (in_valid[idx[SELW-1:0]]) begin
        grant     = idx[SELW-1:0];
        grant_vld = 1'b1;
      end
    end
`ifdef RR_ARB_MUX_LOCK_EN
    // Mid-packet: only the locked channel may be granted.
    if (locked) begin
      grant     = lock_ch;
      grant_vld = in_valid[lock_ch];
    end
`endif
  end

  assign can_load = ~out_valid | out_ready;
  assign take     = rst_n & can_load & grant_vld;
  assign in_ready = take ? (N_IN'(1) << grant) : '0;
  assign ptr_nxt  = (grant == SELW'(N_IN - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant*WIDTH +: WIDTH];
      out_sel   <= grant;
`ifdef RR_ARB_MUX_LOCK_EN
      out_last  <= in_last[grant];
      locked    <= ~in_last[grant];
      lock_ch   <= grant;
      if (in_last[grant])
        rr_ptr <= ptr_nxt;
`else
      rr_ptr    <= ptr_nxt;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios plus randomized traffic against a queue-free reference model.
module tb_rr_arb_mux;
  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [1:0]       out_sel;
`ifdef RR_ARB_MUX_LOCK_EN
  logic [N-1:0]     in_last;
  logic             out_last;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  rr_arb_mux #(.N_IN(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit           m_ov;
  logic [W-1:0] m_od;
  int           m_os;
  int           m_ptr;
  bit           m_locked;
  int           m_lch;
  bit           m_last;

  function automatic int m_grant();
    if (m_locked) return in_valid[m_lch] ? m_lch : -1;
    for (int k = 0; k < N; k++)
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int g;
    g = m_grant();
    if (!rst_n || g < 0 || (m_ov && !out_ready)) return '0;
    return N'(1) << g;
  endfunction

  task automatic model_tick();
    int g;
    bit last;
    g = m_grant();
    if (!rst_n) begin
      m_ov = 0; m_od = '0; m_os = 0; m_ptr = 0; m_locked = 0; m_lch = 0; m_last = 0;
    end else if (m_ready() != '0) begin
      m_ov = 1;
      m_od = in_data[g*W +: W];
      m_os = g;
      last = 1;
`ifdef RR_ARB_MUX_LOCK_EN
      last = in_last[g];
      m_last = last;
`endif
      if (last) begin
        m_locked = 0;
        m_ptr = (g + 1) % N;
      end else begin
        m_locked = 1;
        m_lch = g;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic cycle();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA000_0000 + i;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = '1; out_ready = 1'b1; fill_const();
`ifdef RR_ARB_MUX_LOCK_EN
    in_last = '1;
`endif
    #1;
    for (int c = 0; c < 2; c++) begin
      check_cnt++;
      if (in_ready !== 4'b0000) $display("FAIL reset_in_ready cyc%0d: got %b want 0000", c, in_ready);
      else pass_cnt++;
      cycle();
    end
    check_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else pass_cnt++;
    check_cnt++;
    if (out_sel !== 2'd0 || out_data !== 32'd0)
      $display("FAIL reset_out_regs: got sel %0d data %h want sel 0 data 0", out_sel, out_data);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    rst_n = 1; in_valid = 4'b1111; out_ready = 1'b1; fill_const();
    for (int i = 0; i < 5; i++) begin
      #1;
      check_cnt++;
      if (in_ready !== (4'b0001 << seq[i]))
        $display("FAIL rr_in_ready beat%0d: got %b want %b", i, in_ready, 4'b0001 << seq[i]);
      else pass_cnt++;
      cycle();
      check_cnt++;
      if (out_valid !== 1'b1 || out_sel !== 2'(seq[i]) || out_data !== 32'hA000_0000 + seq[i])
        $display("FAIL rr_out beat%0d: got v%b sel %0d data %h want v1 sel %0d data %h",
                 i, out_valid, out_sel, out_data, seq[i], 32'hA000_0000 + seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    in_valid = 4'b0100; in_data[2*W +: W] = 32'hDEADBEEF; out_ready = 1'b1;
    #1; cycle();
    check_cnt++;
    if (out_sel !== 2'd2 || out_data !== 32'hDEADBEEF)
      $display("FAIL bp_load: got sel %0d data %h want sel 2 data deadbeef", out_sel, out_data);
    else pass_cnt++;
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_cnt++;
      if (in_ready !== 4'b0000) $display("FAIL bp_in_ready cyc%0d: got %b want 0000", c, in_ready);
      else pass_cnt++;
      cycle();
      check_cnt++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 32'hDEADBEEF)
        $display("FAIL bp_hold cyc%0d: got v%b sel %0d data %h want v1 sel 2 data deadbeef",
                 c, out_valid, out_sel, out_data);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    #1;
    check_cnt++;
    if (in_ready !== 4'b1000) $display("FAIL bp_release_ready: got %b want 1000", in_ready);
    else pass_cnt++;
    cycle();
    check_cnt++;
    if (out_sel !== 2'd3) $display("FAIL bp_next_grant: got %0d want 3", out_sel);
    else pass_cnt++;
  endtask

  task automatic test_wrap_sparse();
    in_valid = 4'b0100; out_ready = 1'b1;
    #1; cycle();               // ch2 granted, pointer now 3
    in_valid = 4'b0010;
    #1;
    check_cnt++;
    if (in_ready !== 4'b0010) $display("FAIL wrap_grant: got %b want 0010", in_ready);
    else pass_cnt++;
    cycle();
    check_cnt++;
    if (out_sel !== 2'd1) $display("FAIL wrap_out_sel: got %0d want 1", out_sel);
    else pass_cnt++;
    in_valid = 4'b1111;
    #1;
    check_cnt++;
    if (in_ready !== 4'b0100) $display("FAIL wrap_ptr_after: got %b want 0100", in_ready);
    else pass_cnt++;
    cycle();
  endtask

  task automatic test_reset_midstream();
    in_valid = 4'b0001; out_ready = 1'b0;
    #1; cycle();
    check_cnt++;
    if (out_valid !== 1'b1) $display("FAIL mid_held: got %b want 1", out_valid);
    else pass_cnt++;
    rst_n = 0;
    #1;
    check_cnt++;
    if (in_ready !== 4'b0000) $display("FAIL mid_rst_ready: got %b want 0000", in_ready);
    else pass_cnt++;
    cycle();
    check_cnt++;
    if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid: got %b want 0", out_valid);
    else pass_cnt++;
    rst_n = 1; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    check_cnt++;
    if (in_ready !== 4'b0001) $display("FAIL mid_rst_ptr: got %b want 0001", in_ready);
    else pass_cnt++;
    cycle();
  endtask

`ifdef RR_ARB_MUX_LOCK_EN
  task automatic test_lock();
    int seq [4] = '{0, 0, 0, 1};
    rst_n = 0; #1; cycle();
    rst_n = 1; in_valid = 4'b0011; out_ready = 1'b1; fill_const();
    for (int i = 0; i < 4; i++) begin
      in_last = (i == 2) ? 4'b0011 : 4'b0010;
      #1; cycle();
      check_cnt++;
      if (out_sel !== 2'(seq[i]) || out_valid !== 1'b1)
        $display("FAIL lock_seq beat%0d: got v%b sel %0d want v1 sel %0d", i, out_valid, out_sel, seq[i]);
      else pass_cnt++;
      if (i == 2) begin
        check_cnt++;
        if (out_last !== 1'b1) $display("FAIL lock_out_last: got %b want 1", out_last);
        else pass_cnt++;
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      in_valid  = (c % 3 == 0) ? N'($urandom & $urandom) : N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
`ifdef RR_ARB_MUX_LOCK_EN
      in_last = N'($urandom);
`endif
      #1;
      check_cnt++;
      if (in_ready !== m_ready()) $display("FAIL rand_in_ready cyc%0d: got %b want %b", c, in_ready, m_ready());
      else pass_cnt++;
      cycle();
      check_cnt++;
      if (out_valid !== m_ov ||
          (m_ov && (out_data !== m_od || out_sel !== 2'(m_os))))
        $display("FAIL rand_out cyc%0d: got v%b sel %0d data %h want v%b sel %0d data %h",
                 c, out_valid, out_sel, out_data, m_ov, m_os, m_od);
      else pass_cnt++;
`ifdef RR_ARB_MUX_LOCK_EN
      if (m_ov) begin
        check_cnt++;
        if (out_last !== m_last) $display("FAIL rand_out_last cyc%0d: got %b want %b", c, out_last, m_last);
        else pass_cnt++;
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wrap_sparse();
    test_reset_midstream();
`ifdef RR_ARB_MUX_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
